// File: rtl/rcswitch_uart_sched.sv
// rcswitch_uart_sched: round-robin scheduler sharing one uart_tx between
// NUM_CH rcswitch channel reporters. Events are de-duplicated against the
// last byte sent, coalesced while queued, and sent one byte at a time over
// the uart_tx send/ready handshake with a per-phase timeout.
module rcswitch_uart_sched #(
  parameter int          NUM_CH    = 4,
  parameter logic [7:0]  CHAR_BASE = 8'd65,
  parameter int          TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ev_valid,
  input  logic [NUM_CH-1:0] ev_state,
  input  logic              tx_ready,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  output logic [NUM_CH-1:0] pending,
  output logic              busy,
  output logic [7:0]        coalesce_cnt,
  output logic              timeout_err
);

  localparam int          PW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              rdy_m_q, rdy_s_q;
  logic [PW-1:0]     rr_q, rr_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] latest_q, latest_d;
  logic [NUM_CH-1:0] last_q, last_d;
  logic [NUM_CH-1:0] known_q, known_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        coal_q, coal_d;
  logic              send_q, send_d;
  logic              terr_q, terr_d;
  logic [15:0]       tmo_q, tmo_d;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  int                rr_idx;

  // Two-flop synchronizer for the uart-domain ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_m_q <= 1'b0;
      rdy_s_q <= 1'b0;
    end else begin
      rdy_m_q <= tx_ready;
      rdy_s_q <= rdy_m_q;
    end
  end

  // Round-robin search: first pending channel at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr_idx = (int'(rr_q) + k) % NUM_CH;
      if (!grant_vld && pend_q[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(rr_idx);
      end
    end
  end

  // FSM next state, grant bookkeeping, then event intake against post-grant state.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    pend_d   = pend_q;
    latest_d = latest_q;
    last_d   = last_q;
    known_d  = known_q;
    data_d   = data_q;
    coal_d   = coal_q;
    send_d   = send_q;
    terr_d   = terr_q;

    case (state_q)
      IDLE: begin
        if (grant_vld && rdy_s_q) begin
          state_d             = SEND;
          send_d              = 1'b1;
          data_d              = CHAR_BASE + 8'(grant_idx) +
                                (latest_q[grant_idx] ? 8'd0 : 8'd32);
          last_d[grant_idx]   = latest_q[grant_idx];
          known_d[grant_idx]  = 1'b1;
          pend_d[grant_idx]   = 1'b0;
          rr_d = (grant_idx == PW'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      SEND: begin
        if (!rdy_s_q) begin
          send_d  = 1'b0;
          state_d = DRAIN;
        end else if (tmo_q == TMO) begin
          send_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (rdy_s_q) begin
          state_d = IDLE;
        end else if (tmo_q == TMO) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every state change and only runs in SEND/DRAIN.
    if (state_d != state_q || state_q == IDLE) tmo_d = '0;
    else                                      tmo_d = tmo_q + 16'd1;

    // A channel granted this cycle already shows pending=0 and its new
    // last_sent here, so a same-cycle event is judged as a fresh event.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ev_valid[i]) begin
        if (pend_d[i]) begin
          if (ev_state[i] != latest_d[i] && coal_d != 8'hFF) coal_d = coal_d + 8'd1;
          latest_d[i] = ev_state[i];
        end else if (!(known_d[i] && ev_state[i] == last_d[i])) begin
          pend_d[i]   = 1'b1;
          latest_d[i] = ev_state[i];
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      pend_q   <= '0;
      latest_q <= '0;
      last_q   <= '0;
      known_q  <= '0;
      data_q   <= '0;
      coal_q   <= '0;
      send_q   <= 1'b0;
      terr_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      latest_q <= latest_d;
      last_q   <= last_d;
      known_q  <= known_d;
      data_q   <= data_d;
      coal_q   <= coal_d;
      send_q   <= send_d;
      terr_q   <= terr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign tx_send      = send_q;
  assign tx_data      = data_q;
  assign pending      = pend_q;
  assign busy         = (state_q != IDLE);
  assign coalesce_cnt = coal_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_rcswitch_uart_sched.sv
// Bench for rcswitch_uart_sched: directed event sequences, a transaction-level
// model of the queue/dedupe/coalesce/round-robin rules checked every cycle,
// and literal expectations for the byte stream and timing.
module tb_rcswitch_uart_sched;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ev_valid = '0;
  logic [3:0] ev_state = '0;
  logic       tx_ready = 1'b1;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [3:0] pending;
  logic       busy;
  logic [7:0] coalesce_cnt;
  logic       timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic stuck = 1'b0;

  rcswitch_uart_sched #(.NUM_CH(4), .CHAR_BASE(8'd65), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_state(ev_state),
    .tx_ready(tx_ready), .tx_send(tx_send), .tx_data(tx_data),
    .pending(pending), .busy(busy), .coalesce_cnt(coalesce_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model state
  logic [3:0] m_pend, m_latest, m_last, m_known;
  int         m_rr, m_coal;
  logic [3:0] sv_valid, sv_state;
  logic       prev_send;
  logic [7:0] cap_data;
  logic [7:0] sent_q[$];
  int         hi_run, last_hi_run;

  // Model update and per-cycle comparison, sampled at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_pend = '0; m_latest = '0; m_last = '0; m_known = '0;
      m_rr = 0; m_coal = 0; sv_valid = '0; sv_state = '0;
      prev_send = 1'b0; hi_run = 0;
      chk("rst_tx_send", tx_send, 0);
      chk("rst_pending", pending, 0);
      chk("rst_coalesce", coalesce_cnt, 0);
      chk("rst_busy", busy, 0);
    end else begin
      if (tx_send && !prev_send) begin
        int g;
        g = -1;
        for (int k = 0; k < 4; k++)
          if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        if (g < 0) begin
          chk("spurious_send", 1, 0);
        end else begin
          chk("tx_byte", tx_data, 8'((65 + g + (m_latest[g] ? 0 : 32)) % 256));
          m_last[g]  = m_latest[g];
          m_known[g] = 1'b1;
          m_pend[g]  = 1'b0;
          m_rr       = (g + 1) % 4;
        end
        sent_q.push_back(tx_data);
        cap_data = tx_data;
      end else if (tx_send) begin
        chk("data_stable", tx_data, cap_data);
      end
      for (int i = 0; i < 4; i++) begin
        if (sv_valid[i]) begin
          if (m_pend[i]) begin
            if (sv_state[i] != m_latest[i] && m_coal < 255) m_coal++;
            m_latest[i] = sv_state[i];
          end else if (!(m_known[i] && sv_state[i] == m_last[i])) begin
            m_pend[i]   = 1'b1;
            m_latest[i] = sv_state[i];
          end
        end
      end
      chk("pending_model", pending, m_pend);
      chk("coalesce_model", coalesce_cnt, m_coal);
      if (tx_send) hi_run++;
      else if (hi_run != 0) begin last_hi_run = hi_run; hi_run = 0; end
      sv_valid  = ev_valid;
      sv_state  = ev_state;
      prev_send = tx_send;
    end
  end

  // uart_tx stand-in: accepts a byte by dropping ready, later raises it again.
  initial begin
    forever begin
      @(negedge clk);
      if (!stuck && tx_send && tx_ready) begin
        repeat (2) @(negedge clk);
        tx_ready = 1'b0;
        repeat (6) @(negedge clk);
        tx_ready = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [3:0] v, input logic [3:0] s);
    ev_valid = v;
    ev_state = s;
    tick(1);
    ev_valid = '0;
    ev_state = '0;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int c = 0;
    while (sent_q.size() < n && c < budget) begin tick(1); c++; end
    chk("wait_sent_bound", (c < budget), 1);
  endtask

  task automatic wait_quiet(input int budget);
    int c = 0;
    while (!(busy == 0 && pending == 0 && tx_ready == 1 && tx_send == 0) && c < budget) begin
      tick(1); c++;
    end
    chk("wait_quiet_bound", (c < budget), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
  endtask

  initial begin
    int n0, c;
    // 1: reset values, first byte and its latency
    tick(3);
    chk("reset_tx_data", tx_data, 0);
    chk("reset_timeout_err", timeout_err, 0);
    rst = 1'b0;
    tick(4);
    ev(4'b0001, 4'b0001);
    chk("t1_pending_t1", pending, 4'b0001);
    chk("t1_send_t1", tx_send, 0);
    tick(1);
    chk("t1_send_t2", tx_send, 1);
    chk("t1_data_A", tx_data, 8'h41);
    chk("t1_busy", busy, 1);
    chk("t1_pending_t2", pending, 0);
    wait_quiet(60);

    // 2: duplicate suppressed, OFF reported
    n0 = sent_q.size();
    ev(4'b0001, 4'b0001);
    tick(15);
    chk("t2_dup_no_send", sent_q.size(), n0);
    ev(4'b0001, 4'b0000);
    wait_sent(n0 + 1, 30);
    chk("t2_data_a", sent_q[n0], 8'h61);
    wait_quiet(60);

    // 3: all four at once from rr=0, then wrap
    do_reset();
    n0 = sent_q.size();
    ev(4'b1111, 4'b1111);
    wait_sent(n0 + 4, 200);
    chk("t3_A", sent_q[n0],     8'h41);
    chk("t3_B", sent_q[n0 + 1], 8'h42);
    chk("t3_C", sent_q[n0 + 2], 8'h43);
    chk("t3_D", sent_q[n0 + 3], 8'h44);
    wait_quiet(60);
    ev(4'b1010, 4'b0000);
    wait_sent(n0 + 6, 100);
    chk("t3_b", sent_q[n0 + 4], 8'h62);
    chk("t3_d", sent_q[n0 + 5], 8'h64);
    wait_quiet(60);

    // 4: coalescing behind a busy transfer
    n0 = sent_q.size();
    ev(4'b0001, 4'b0000);
    wait_sent(n0 + 1, 30);
    ev(4'b0100, 4'b0000);
    ev(4'b0100, 4'b0100);
    ev(4'b0100, 4'b0000);
    chk("t4_coalesce", coalesce_cnt, 2);
    wait_sent(n0 + 2, 60);
    chk("t4_a", sent_q[n0],     8'h61);
    chk("t4_c", sent_q[n0 + 1], 8'h63);
    wait_quiet(60);
    tick(10);
    chk("t4_one_c", sent_q.size(), n0 + 2);

    // 5: handshake timeout, other pending channel still serviced
    stuck = 1'b1;
    n0 = sent_q.size();
    ev(4'b0001, 4'b0001);
    wait_sent(n0 + 1, 20);
    chk("t5_no_err_yet", timeout_err, 0);
    ev(4'b0010, 4'b0010);
    c = 0;
    while (tx_send && c < 60) begin tick(1); c++; end
    chk("t5_fall_bound", (c < 60), 1);
    chk("t5_send_low", tx_send, 0);
    chk("t5_timeout_err", timeout_err, 1);
    chk("t5_idle", busy, 0);
    stuck = 1'b0;
    tick(1);
    chk("t5_high_cycles", last_hi_run, TMO + 1);
    wait_sent(n0 + 2, 60);
    chk("t5_A", sent_q[n0],     8'h41);
    chk("t5_B", sent_q[n0 + 1], 8'h42);
    wait_quiet(60);

    // 6: reset during SEND, then pre-reset state reported again
    n0 = sent_q.size();
    ev(4'b1100, 4'b1100);
    wait_sent(n0 + 1, 20);
    chk("t6_C", sent_q[n0], 8'h43);
    chk("t6_pre_coalesce", coalesce_cnt, 2);
    chk("t6_pre_pending", pending, 4'b1000);
    chk("t6_in_send", tx_send, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_send", tx_send, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_coalesce", coalesce_cnt, 0);
    chk("t6_rst_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    c = 0;
    while (!tx_ready && c < 40) begin tick(1); c++; end
    chk("t6_ready_bound", (c < 40), 1);
    tick(4);
    n0 = sent_q.size();
    ev(4'b0100, 4'b0100);
    wait_sent(n0 + 1, 40);
    chk("t6_C_again", sent_q[n0], 8'h43);
    wait_quiet(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
